// File: rtl/sat_counter.sv
// Saturating up-counter with a load-to-one clear.
// Holds at all-ones until the next clear.
module sat_counter #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr1,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr1) begin
      r_count <= ONE;
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/quadencoder_velocity.sv
// Windowed velocity and edge-period estimator fed by a
// quadrature decoder position count.
module quadencoder_velocity #(
  parameter int BITS        = 32,
  parameter int WINDOW      = 1000,
  parameter int PERIOD_BITS = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BITS-1:0]        position,
  output logic [BITS-1:0]        velocity,
  output logic                   valid,
  output logic [PERIOD_BITS-1:0] period,
  output logic                   direction,
  output logic                   standstill
);
  localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(WINDOW - 1);
  localparam logic [WCW-1:0] W_ONE  = WCW'(1);
  localparam logic [PERIOD_BITS-1:0] SAT_MAX = '1;

  logic [WCW-1:0]         r_wcnt;
  logic                   r_primed;
  logic [BITS-1:0]        r_pos_last;
  logic [BITS-1:0]        r_pos_prev;
  logic                   r_prev_ok;
  logic                   r_seen;
  logic [BITS-1:0]        r_vel;
  logic                   r_valid;
  logic [PERIOD_BITS-1:0] r_period;
  logic                   r_dir;
  logic                   r_stand;

  logic [BITS-1:0]        w_step;
  logic                   w_change;
  logic                   w_dir_new;
  logic [PERIOD_BITS-1:0] w_ecnt;

  // No previous sample exists on the first cycle after reset
  assign w_step    = position - r_pos_prev;
  assign w_change  = r_prev_ok && (position != r_pos_prev);
  assign w_dir_new = ~w_step[BITS-1];

  sat_counter #(
    .WIDTH(PERIOD_BITS)
  ) u_edge_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr1 (w_change),
    .i_inc  (1'b1),
    .o_count(w_ecnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt     <= '0;
      r_primed   <= 1'b0;
      r_pos_last <= '0;
      r_vel      <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_wcnt == W_LAST) begin
        r_wcnt     <= '0;
        r_pos_last <= position;
        r_primed   <= 1'b1;
        if (r_primed) begin
          r_vel   <= position - r_pos_last;
          r_valid <= 1'b1;
        end
      end else begin
        r_wcnt <= r_wcnt + W_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos_prev <= '0;
      r_prev_ok  <= 1'b0;
      r_seen     <= 1'b0;
      r_period   <= '0;
      r_dir      <= 1'b0;
      r_stand    <= 1'b1;
    end else begin
      r_pos_prev <= position;
      r_prev_ok  <= 1'b1;
      if (w_change) begin
        if (r_seen && (w_dir_new == r_dir)) begin
          r_period <= w_ecnt;
        end
        r_dir   <= w_dir_new;
        r_seen  <= 1'b1;
        r_stand <= 1'b0;
      end else if (w_ecnt == SAT_MAX) begin
        r_stand <= 1'b1;
      end
    end
  end

  assign velocity   = r_vel;
  assign valid      = r_valid;
  assign period     = r_period;
  assign direction  = r_dir;
  assign standstill = r_stand;
endmodule

// File: tb/tb_quadencoder_velocity.sv
// Randomized bench for quadencoder_velocity against a
// history-based reference model.
module tb_quadencoder_velocity;
  localparam int BITS = 32;
  localparam int W    = 12;
  localparam int PB   = 4;
  localparam int SMAX = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [BITS-1:0] position;
  logic [BITS-1:0] velocity;
  logic            valid;
  logic [PB-1:0]   period;
  logic            direction;
  logic            standstill;

  quadencoder_velocity #(
    .BITS(BITS),
    .WINDOW(W),
    .PERIOD_BITS(PB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .position  (position),
    .velocity  (velocity),
    .valid     (valid),
    .period    (period),
    .direction (direction),
    .standstill(standstill)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [BITS-1:0] hist[$];
  int              c;
  logic [BITS-1:0] e_vel;
  logic            e_valid;
  int              e_per;
  logic            e_dir;
  logic            e_stand;
  bit              have;
  int              last_c;
  logic [BITS-1:0] pos;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h",
               tag, c, got, exp);
    end
  endtask

  task automatic check_all();
    check("velocity", 64'(velocity), 64'(e_vel));
    check("valid", 64'(valid), 64'(e_valid));
    check("period", 64'(period), 64'(e_per));
    check("direction", 64'(direction), 64'(e_dir));
    check("standstill", 64'(standstill), 64'(e_stand));
  endtask

  task automatic model_reset();
    hist.delete();
    c       = 0;
    e_vel   = '0;
    e_valid = 1'b0;
    e_per   = 0;
    e_dir   = 1'b0;
    e_stand = 1'b1;
    have    = 1'b0;
    last_c  = 0;
  endtask

  // Expected outputs after the edge that samples p at cycle c
  task automatic model_step(input logic [BITS-1:0] p);
    logic [BITS-1:0] d;
    logic            dn;
    int              since;
    hist.push_back(p);
    e_valid = 1'b0;
    if ((c % W) == W - 1 && c >= 2 * W - 1) begin
      e_vel   = p - hist[c - W];
      e_valid = 1'b1;
    end
    if (c >= 1 && p != hist[c - 1]) begin
      d  = p - hist[c - 1];
      dn = (d == 32'd1);
      if (have && dn == e_dir) begin
        since = c - last_c;
        e_per = (since > SMAX) ? SMAX : since;
      end
      e_dir   = dn;
      e_stand = 1'b0;
      have    = 1'b1;
      last_c  = c;
    end else begin
      since = have ? c - last_c : c;
      if (since >= SMAX) e_stand = 1'b1;
    end
    c++;
  endtask

  task automatic drive(input logic [BITS-1:0] p);
    check_all();
    position = p;
    model_step(p);
    @(negedge clk);
  endtask

  // mode 0 hold, 1 up every n, 2 down every n, 3 random walk
  task automatic run_phase(input int mode, input int len, input int n);
    int r;
    for (int i = 0; i < len; i++) begin
      case (mode)
        1: if (i % n == n - 1) pos = pos + 1;
        2: if (i % n == n - 1) pos = pos - 1;
        3: begin
          r = $urandom_range(0, 2);
          if (r == 1) pos = pos + 1;
          else if (r == 2) pos = pos - 1;
        end
        default: ;
      endcase
      drive(pos);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_velocity", 64'(velocity), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_period", 64'(period), 64'd0);
    check("rst_direction", 64'(direction), 64'd0);
    check("rst_standstill", 64'(standstill), 64'd1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    pos      = 32'h7FFF_FFE0;
    position = pos;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_phase(1, 64, 1);
    run_phase(1, 80, 4);
    run_phase(2, 72, 3);
    run_phase(1, 9, 3);
    run_phase(0, 30, 1);
    run_phase(1, 20, 5);
    repeat (15)
      run_phase($urandom_range(0, 3), $urandom_range(10, 60),
                $urandom_range(1, 7));
    run_phase(1, 17, 4);
    do_reset();
    pos = 32'd100;
    run_phase(0, 40, 1);
    run_phase(1, 40, 2);
    repeat (15)
      run_phase($urandom_range(0, 3), $urandom_range(10, 60),
                $urandom_range(1, 18));
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/quadencoder_velocity.md
# quadencoder_velocity

Downstream consumer of the quadrature decoder's signed position count. Produces a windowed velocity (count delta per fixed sample window) and an edge-period measurement (clock cycles between consecutive count changes) for low-speed estimation, plus direction and standstill flags. Sits between the decoder and the host register interface. All outputs are registered.

## Interface
- BITS, 32, width of position input and velocity output (two's complement)
- WINDOW, 1000, sample window length in clk cycles (≥2)
- PERIOD_BITS, 24, width of edge-period counter/output
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- position  input  BITS  signed encoder count, changes by at most ±1 per cycle
- velocity  output  BITS  signed count delta over last completed window
- valid  output  1  one-cycle pulse when velocity updates
- period  output  PERIOD_BITS  cycles between the last two same-direction count changes
- direction  output  1  1 = last change was +1, 0 = last change was −1
- standstill  output  1  no change for 2^PERIOD_BITS−1 cycles, or none since reset

## Operation
- Reset values: velocity=0, valid=0, period=0, direction=0, standstill=1; internal window counter=0, primed=0, edge counter=0, seen_edge=0.
- Window: counter runs 0..WINDOW−1 and wraps. On the cycle it equals WINDOW−1:
  - if primed: velocity <= position − pos_last; valid <= 1.
  - always: pos_last <= position; primed <= 1.
  - The first window after reset only captures; no valid pulse.
- Subtraction is modulo 2^BITS; position wrap (0x7FFFFFFF → 0x80000000) yields delta +1, not a large negative value.
- Change detect: pos_prev registers position every cycle; change = (position != pos_prev); step sign = MSB of (position − pos_prev).
- Edge counter: on change, reload to 1; otherwise increment, saturating at 2^PERIOD_BITS−1.
- On change:
  - if seen_edge and the step sign equals the stored direction: period <= edge counter value before reload.
  - if direction reverses, or this is the first change since reset: period is unchanged.
  - direction <= step sign inverted (1 for +1); seen_edge <= 1; standstill <= 0.
- standstill <= 1 when the edge counter reaches saturation without a change. period holds its last value.
- Window end and a change in the same cycle are handled independently; the window uses the current position.
- Reset asserted mid-window or mid-period clears everything immediately; the first window after release is a capture window again.

## Timing
- position is sampled on every rising clk edge; no input synchronizer (input is already clk-domain).
- velocity/valid: registered, valid high exactly one cycle, on the edge following the window-end sample; one pulse per WINDOW cycles after priming.
- period/direction/standstill: update on the edge following the cycle the change is seen (1-cycle latency).
- Steady state for a constant rate of one change every N cycles (N < 2^PERIOD_BITS): period = N.

## Structure
- No shared-package entries; the saturation maximum is a localparam derived from PERIOD_BITS.
- One natural sub-module: `sat_counter` (parameter WIDTH; ports clk, rst, clear-to-1, increment; saturating output), instantiated for the edge counter.
- Window counter, delta subtract and change detect stay in the top module.

## Test plan
- Reset, then hold position=100 with WINDOW=10:
  - first valid at cycle 20 with velocity=0.
  - no valid at cycle 10.
- Position +1 every 4 cycles, WINDOW=20:
  - after priming, each valid shows velocity=5.
  - period=4, direction=1, standstill=0.
- Position −1 every 3 cycles:
  - velocity negative (−6 for WINDOW=18).
  - direction=0, period=3.
  - at the reversal edge, period keeps its previous value.
- Wrap: ramp position through 0x7FFFFFFE..0x80000001, BITS=32:
  - velocity equals the true +delta.
- PERIOD_BITS=4, stop changes:
  - standstill rises 15 cycles after the last change.
  - period holds; the next change clears standstill without updating period.
- Assert rst mid-window:
  - all outputs return to reset values asynchronously.
  - the first post-reset window produces no valid.
